// File: rtl/nios_pio_led_blink_pkg.sv
// Shared register map and bus helpers for the Nios II PIO family
// (output, blink, and future input/IRQ variants).
package nios_pio_pkg;

    localparam int PIO_ADDR_W = 3;

    localparam logic [PIO_ADDR_W-1:0] PIO_DATA   = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_BLINK  = 3'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_PERIOD = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_STATUS = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] PIO_OUTSET = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] PIO_OUTCLR = 3'd5;

    // Avalon zero-wait-state slave write: accepted on any edge with this true.
    function automatic logic pio_write_strobe(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/nios_pio_led_blink_if.sv
// Avalon-MM slave bus bundle for the PIO register block.
//
// Handshake: a write is accepted at every rising clk edge where chipselect
// is high and write_n is low; there is no waitrequest, so the master never
// stalls. readdata is a combinational function of address alone and is
// valid whenever address is stable (read latency 0, chipselect ignored).
interface nios_pio_led_blink_if;
    import nios_pio_pkg::*;

    logic [PIO_ADDR_W-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [31:0]           readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/nios_pio_led_blink_timebase.sv
// Blink timebase: free-running half-period counter that toggles phase
// every period+1 cycles; a restart zeroes the count and forces phase high.
module pio_blink_timebase #(
    parameter int PERIOD_W = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt;
    logic                tick;

    assign tick = (cnt == period);

    // Restart beats tick so a shorter new period never waits out a full wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/nios_pio_led_blink.sv
// Avalon-MM output PIO with atomic set/clear and per-bit hardware blink,
// driving board LEDs from the DATA register gated by the blink phase.
module nios_pio_led_blink
    import nios_pio_pkg::*;
#(
    parameter int                  WIDTH        = 8,
    parameter int                  PERIOD_W     = 26,
    parameter logic [WIDTH-1:0]    DATA_RESET   = '0,
    parameter logic [WIDTH-1:0]    BLINK_RESET  = '0,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = PERIOD_W'(24999999)
) (
    input  logic                 clk,
    input  logic                 reset,
    nios_pio_led_blink_if.slave  bus,
    output logic [WIDTH-1:0]     out_port
);

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    blink_q;
    logic [PERIOD_W-1:0] period_q;
    logic                phase;
    logic                wr_en;
    logic                period_wr;
    logic [WIDTH-1:0]    wr_bits;
    logic                unused_wdata;

    assign wr_en        = pio_write_strobe(bus.chipselect, bus.write_n);
    assign period_wr    = wr_en && (bus.address == PIO_PERIOD);
    assign wr_bits      = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= DATA_RESET;
            blink_q  <= BLINK_RESET;
            period_q <= PERIOD_RESET;
        end else if (wr_en) begin
            case (bus.address)
                PIO_DATA:   data_q   <= wr_bits;
                PIO_BLINK:  blink_q  <= wr_bits;
                PIO_PERIOD: period_q <= bus.writedata[PERIOD_W-1:0];
                PIO_OUTSET: data_q   <= data_q | wr_bits;
                PIO_OUTCLR: data_q   <= data_q & ~wr_bits;
                default:    ;
            endcase
        end
    end

    pio_blink_timebase #(
        .PERIOD_W (PERIOD_W)
    ) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .period  (period_q),
        .restart (period_wr),
        .phase   (phase)
    );

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            PIO_DATA:   bus.readdata[WIDTH-1:0]    = data_q;
            PIO_BLINK:  bus.readdata[WIDTH-1:0]    = blink_q;
            PIO_PERIOD: bus.readdata[PERIOD_W-1:0] = period_q;
            PIO_STATUS: bus.readdata[0]            = phase;
            default:    bus.readdata               = '0;
        endcase
    end

    // Blinking bits are lit only in phase 1; others follow DATA directly.
    assign out_port = data_q & (~blink_q | {WIDTH{phase}});

endmodule

// File: tb/tb_nios_pio_led_blink.sv
// Directed bench for nios_pio_led_blink: an 8-bit instance with DATA_RESET
// 0xA5 and a 4-bit instance with a short reset period for blink timing.
module tb_nios_pio_led_blink;
    import nios_pio_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst4;
    logic [7:0] out_port;
    logic [3:0] out_port4;
    int         checks = 0;
    int         errors = 0;

    nios_pio_led_blink_if bus ();
    nios_pio_led_blink_if bus4 ();

    always #5 clk = ~clk;

    nios_pio_led_blink #(
        .WIDTH        (8),
        .PERIOD_W     (26),
        .DATA_RESET   (8'hA5),
        .BLINK_RESET  (8'h00),
        .PERIOD_RESET (26'd24999999)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus),
        .out_port (out_port)
    );

    nios_pio_led_blink #(
        .WIDTH        (4),
        .PERIOD_W     (4),
        .DATA_RESET   (4'hF),
        .BLINK_RESET  (4'h1),
        .PERIOD_RESET (4'd3)
    ) dut4 (
        .clk      (clk),
        .reset    (rst4),
        .bus      (bus4),
        .out_port (out_port4)
    );

    task automatic bus_idle();
        bus.chipselect  = 1'b0;
        bus.write_n     = 1'b1;
        bus.address     = '0;
        bus.writedata   = '0;
        bus4.chipselect = 1'b0;
        bus4.write_n    = 1'b1;
        bus4.address    = '0;
        bus4.writedata  = '0;
    endtask

    // One bus cycle on the selected instance; returns 1 time unit after the edge.
    task automatic bus_cycle(input bit sel, input logic cs, input logic wn,
                             input logic [2:0] a, input logic [31:0] d);
        if (!sel) begin
            bus.chipselect = cs;
            bus.write_n    = wn;
            bus.address    = a;
            bus.writedata  = d;
        end else begin
            bus4.chipselect = cs;
            bus4.write_n    = wn;
            bus4.address    = a;
            bus4.writedata  = d;
        end
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
        bus_cycle(sel, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, output logic [31:0] d);
        if (!sel) bus.address = a;
        else      bus4.address = a;
        #1;
        d = sel ? bus4.readdata : bus.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL reset_out_port got %h expected a5", out_port); end
        checks++; if (out_port4 !== 4'hF) begin errors++; $display("FAIL reset_out_port4 got %h expected f", out_port4); end
        rd(0, PIO_DATA, v);
        checks++; if (v !== 32'h000000A5) begin errors++; $display("FAIL reset_data got %h expected 000000a5", v); end
        rd(0, PIO_BLINK, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_blink got %h expected 0", v); end
        rd(0, PIO_PERIOD, v);
        checks++; if (v !== 32'd24999999) begin errors++; $display("FAIL reset_period got %0d expected 24999999", v); end
        rd(0, PIO_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_status got %h expected 1", v); end
    endtask

    task automatic test_set_clear();
        logic [31:0] v;
        wr(0, PIO_DATA, 32'h0000000F);
        checks++; if (out_port !== 8'h0F) begin errors++; $display("FAIL data_write_out got %h expected 0f", out_port); end
        rd(0, PIO_DATA, v);
        checks++; if (v !== 32'h0F) begin errors++; $display("FAIL data_write got %h expected 0f", v); end
        wr(0, PIO_OUTSET, 32'h00000030);
        rd(0, PIO_DATA, v);
        checks++; if (v !== 32'h3F) begin errors++; $display("FAIL outset got %h expected 3f", v); end
        wr(0, PIO_OUTCLR, 32'h00000003);
        rd(0, PIO_DATA, v);
        checks++; if (v !== 32'h3C) begin errors++; $display("FAIL outclr got %h expected 3c", v); end
        checks++; if (out_port !== 8'h3C) begin errors++; $display("FAIL outclr_out got %h expected 3c", out_port); end
        for (int a = 4; a < 8; a++) begin
            rd(0, 3'(a), v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL read_addr%0d got %h expected 0", a, v); end
        end
    endtask

    task automatic test_blink();
        logic [31:0] v;
        logic        exp_ph;
        wr(0, PIO_DATA, 32'hFF);
        wr(0, PIO_BLINK, 32'h01);
        wr(0, PIO_PERIOD, 32'd3);
        for (int k = 0; k < 16; k++) begin
            exp_ph = ((k / 4) % 2) == 0;
            checks++; if (out_port !== (exp_ph ? 8'hFF : 8'hFE)) begin errors++; $display("FAIL blink_out k=%0d got %h expected %h", k, out_port, exp_ph ? 8'hFF : 8'hFE); end
            rd(0, PIO_STATUS, v);
            checks++; if (v !== {31'b0, exp_ph}) begin errors++; $display("FAIL blink_status k=%0d got %h expected %h", k, v, exp_ph); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_period_restart();
        logic [31:0] v;
        logic        exp_ph;
        wr(0, PIO_PERIOD, 32'd9);
        repeat (7) @(posedge clk);
        #1;
        rd(0, PIO_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL restart_pre_status got %h expected 1", v); end
        wr(0, PIO_PERIOD, 32'd2);
        for (int k = 0; k < 7; k++) begin
            exp_ph = (k < 3) || (k == 6);
            rd(0, PIO_STATUS, v);
            checks++; if (v !== {31'b0, exp_ph}) begin errors++; $display("FAIL restart_status k=%0d got %h expected %h", k, v, exp_ph); end
            checks++; if (out_port !== (exp_ph ? 8'hFF : 8'hFE)) begin errors++; $display("FAIL restart_out k=%0d got %h expected %h", k, out_port, exp_ph ? 8'hFF : 8'hFE); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_gating();
        logic [31:0] v;
        bus_cycle(0, 1'b0, 1'b0, PIO_DATA, 32'h00);
        bus_cycle(0, 1'b1, 1'b1, PIO_DATA, 32'h00);
        bus_cycle(0, 1'b0, 1'b0, PIO_PERIOD, 32'd5);
        bus_cycle(0, 1'b1, 1'b1, PIO_BLINK, 32'hFF);
        wr(0, PIO_STATUS, 32'hFFFFFFFF);
        wr(0, 3'd6, 32'hFFFFFFFF);
        wr(0, 3'd7, 32'hFFFFFFFF);
        rd(0, PIO_DATA, v);
        checks++; if (v !== 32'hFF) begin errors++; $display("FAIL gate_data got %h expected ff", v); end
        rd(0, PIO_BLINK, v);
        checks++; if (v !== 32'h01) begin errors++; $display("FAIL gate_blink got %h expected 01", v); end
        rd(0, PIO_PERIOD, v);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL gate_period got %0d expected 2", v); end
    endtask

    task automatic test_width4();
        logic [31:0] v;
        wr(1, PIO_DATA, 32'hFFFFFFFF);
        rd(1, PIO_DATA, v);
        checks++; if (v !== 32'h0000000F) begin errors++; $display("FAIL w4_data got %h expected 0000000f", v); end
        wr(1, PIO_PERIOD, 32'hFFFFFFFF);
        rd(1, PIO_PERIOD, v);
        checks++; if (v !== 32'h0000000F) begin errors++; $display("FAIL w4_period got %h expected 0000000f", v); end
        wr(1, PIO_DATA, 32'h00000000);
        checks++; if (out_port4 !== 4'h0) begin errors++; $display("FAIL w4_out got %h expected 0", out_port4); end
    endtask

    task automatic test_reset_mid_blink();
        logic [31:0] v;
        logic        exp_ph;
        wr(0, PIO_DATA, 32'h00);
        rst = 1'b1;
        wr(0, PIO_OUTSET, 32'hFF);
        rst = 1'b0;
        checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL rmb_out got %h expected a5", out_port); end
        rd(0, PIO_DATA, v);
        checks++; if (v !== 32'hA5) begin errors++; $display("FAIL rmb_data got %h expected a5", v); end
        rd(0, PIO_BLINK, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rmb_blink got %h expected 0", v); end
        rd(0, PIO_PERIOD, v);
        checks++; if (v !== 32'd24999999) begin errors++; $display("FAIL rmb_period got %0d expected 24999999", v); end
        rd(0, PIO_STATUS, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL rmb_status got %h expected 1", v); end

        rst4 = 1'b1;
        bus4.chipselect = 1'b1;
        bus4.write_n    = 1'b0;
        bus4.address    = PIO_OUTSET;
        bus4.writedata  = 32'hFF;
        @(posedge clk);
        #1;
        bus_idle();
        rst4 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_ph = (k < 4);
            checks++; if (out_port4 !== (exp_ph ? 4'hF : 4'hE)) begin errors++; $display("FAIL rmb4_out k=%0d got %h expected %h", k, out_port4, exp_ph ? 4'hF : 4'hE); end
            @(posedge clk);
            #1;
        end
        rd(1, PIO_PERIOD, v);
        checks++; if (v !== 32'd3) begin errors++; $display("FAIL rmb4_period got %0d expected 3", v); end
    endtask

    initial begin
        bus_idle();
        rst  = 1'b1;
        rst4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst4 = 1'b0;

        test_reset();
        test_set_clear();
        test_blink();
        test_period_restart();
        test_gating();
        test_width4();
        test_reset_mid_blink();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_pio_led_blink.md
# nios_pio_led_blink

Parametrised Avalon-MM output PIO for the Nios II system, the successor to the fixed 8-bit LED PIO. Drives `WIDTH` output pins from a data register. Adds atomic bit set/clear registers and a per-bit hardware blink mode, so that LEDs toggle at a programmable half-period with no CPU involvement. Sits on the Nios II data master as a zero-wait-state slave, and its `out_port` drives board LEDs.

## Interface
Parameters:
- `WIDTH`, 8: number of output bits, 1..32.
- `PERIOD_W`, 26: width of the blink half-period register, 1..32.
- `DATA_RESET`, 0: reset value of DATA (`WIDTH` bits).
- `BLINK_RESET`, 0: reset value of BLINK_EN (`WIDTH` bits).
- `PERIOD_RESET`, 24999999: reset value of PERIOD. This gives 0.5 s at 50 MHz. Must fit in `PERIOD_W` bits.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  word register offset.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, combinational.
- `out_port`  out  `WIDTH`  LED drive.

## Operation
- A write is accepted when `chipselect && !write_n` at a `clk` rising edge.
- Reads are combinational on `address`. `chipselect` does not gate `readdata`. Unused upper bits read as 0.
- Register map:
  - 0 DATA, R/W: `writedata[WIDTH-1:0]` is loaded into DATA.
  - 1 BLINK_EN, R/W: per-bit blink enable.
  - 2 PERIOD, R/W: blink half-period minus 1, in clk cycles.
  - 3 STATUS, RO: bit0 = current blink phase. Other bits read 0.
  - 4 OUTSET, WO: DATA <= DATA | `writedata`. Reads 0.
  - 5 OUTCLEAR, WO: DATA <= DATA & ~`writedata`. Reads 0.
  - 6, 7 reserved: writes ignored, reads 0. Writes to STATUS are ignored.
- Blink timebase:
  - A free-running counter `cnt` (`PERIOD_W` bits) increments every cycle.
  - When `cnt == PERIOD`: `cnt` <= 0 and `phase` toggles.
  - The result is a toggle every PERIOD+1 cycles. PERIOD = 0 toggles every cycle.
- Writing PERIOD restarts the timebase: `cnt` <= 0 and `phase` <= 1 in the same edge. This avoids a long wrap when the new PERIOD is below the current `cnt`. The timebase has no other way to wrap past PERIOD.
- Output: `out_port[i] = DATA[i] & (~BLINK_EN[i] | phase)`, purely combinational from registers.
  - A blinking bit is lit during phase 1 and dark during phase 0.
  - A non-blinking bit follows DATA.
- Simultaneous events:
  - A register write and a timebase tick in the same cycle both take effect. The exception is a PERIOD write, which overrides the tick.
  - OUTSET and OUTCLEAR cannot coincide (single address).
- Reset values:
  - DATA = `DATA_RESET`, BLINK_EN = `BLINK_RESET`, PERIOD = `PERIOD_RESET`.
  - `cnt` = 0, `phase` = 1.
  - So `out_port` = `DATA_RESET` in the cycle after reset. `readdata` reflects reset registers.
- Reset asserted mid-operation overrides any concurrent write and any timebase tick.

## Timing
- Write-to-register latency is 1 cycle. The new value is visible on `readdata` and `out_port` right after the accepting edge.
- Read latency is 0 (Avalon readLatency 0, no waitrequest).
- Blink: the first toggle after reset or a PERIOD write occurs at edge PERIOD+1. The phase-0 to phase-1 transition is then exactly PERIOD+1 cycles later.
- No combinational path from `writedata` to `out_port`.

## Structure
- Shared package `nios_pio_pkg`: register offset constants (`PIO_DATA`=0, `PIO_BLINK`=1, `PIO_PERIOD`=2, `PIO_STATUS`=3, `PIO_OUTSET`=4, `PIO_OUTCLR`=5) and the address width (3). These are reused by future input/IRQ PIO variants.
- One sub-module, `pio_blink_timebase`:
  - Inputs: `clk`, `reset`, `period`, `restart`.
  - Output: `phase`.
  - Holds `cnt` and `phase`.
- The top level holds the register file, read mux and output gating.

## Test plan
- Reset: hold `reset` 2 cycles with `DATA_RESET`=8'hA5.
  - `out_port` = 8'hA5.
  - Reads: addr0 = 0xA5, addr1 = 0, addr2 = 24999999, addr3 = 1.
- Set/clear: write DATA = 0x0F, then OUTSET = 0x30, then OUTCLEAR = 0x03.
  - DATA reads 0x0F, then 0x3F, then 0x3C, each 1 cycle after its write.
  - Reads of addr 4/5/6/7 = 0.
- Blink: PERIOD = 3, DATA = 0xFF, BLINK_EN = 0x01.
  - `out_port` alternates 0xFF for 4 cycles and 0xFE for 4 cycles.
  - Bits 7:1 stay high.
  - STATUS bit0 tracks the phase.
- Period restart: with PERIOD = 9 and `cnt` at 7, write PERIOD = 2.
  - `phase` = 1 on the next cycle.
  - First toggle exactly 3 cycles after the write edge; no 2^`PERIOD_W` wrap.
- Gating/ignored writes:
  - A write with `chipselect`=0 or `write_n`=1 leaves all registers unchanged.
  - A write of 0xFFFFFFFF to STATUS or to addr 7 changes nothing.
  - With `WIDTH`=4, writing DATA = 0xFFFFFFFF reads back 0x0000000F.
- Reset mid-blink: assert `reset` the same cycle as an OUTSET write of 0xFF.
  - All registers return to reset values; the write is lost.
  - Blink resumes with its first toggle PERIOD+1 cycles after reset deasserts.
